// File: rtl/fft_out_sched_pkg.sv
// Shared FFT output-scheduler definitions: default frame size, ping-pong bank
// state encoding and the bit-reversal helper used for write addressing.
package fft_out_sched_pkg;

   localparam int FFT_N    = 32;
   localparam int FFT_LOGN = 5;

   typedef enum logic [1:0] {
      BANK_EMPTY = 2'b00,
      BANK_FULL  = 2'b01,
      BANK_DRAIN = 2'b10
   } bank_state_t;

   // Reverses the low 'width' bits of v; bits above width come back as zero.
   function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int width);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < width) r = {r[30:0], v[i[4:0]]};
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bank_fsm.sv
// Lifecycle of one ping-pong bank: EMPTY while being filled, FULL once the
// frame is complete, DRAIN while the reader walks it in natural order.
module fft_bank_fsm
   import fft_out_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_done,
   input  logic        drain_start,
   input  logic        rd_done,
   output bank_state_t state
);

   bank_state_t state_reg, state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= BANK_EMPTY;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         BANK_EMPTY: if (wr_done)     state_next = BANK_FULL;
         BANK_FULL:  if (drain_start) state_next = BANK_DRAIN;
         BANK_DRAIN: if (rd_done)     state_next = BANK_EMPTY;
         default:                     state_next = BANK_EMPTY;
      endcase
   end

   assign state = state_reg;

endmodule

// File: rtl/fft_out_sched.sv
// Ping-pong reorder scheduler: writes FFT outputs bit-reversed into one bank
// while the other bank is read out in natural order.
module fft_out_sched
   import fft_out_sched_pkg::*;
#(
   parameter int N    = FFT_N,
   parameter int LOGN = FFT_LOGN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            valid_i,
   input  logic            rd_ready_i,
   output logic            wr_en,
   output logic            wr_bank,
   output logic [LOGN-1:0] wr_addr,
   output logic            rd_en,
   output logic            rd_bank,
   output logic [LOGN-1:0] rd_addr,
   output logic            valid_o,
   output logic            last_o,
   output logic            overflow
);

   localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);

   bank_state_t     bank_state [2];
   logic [1:0]      wr_done, drain_start, rd_done;
   logic [LOGN-1:0] wcnt_reg, rcnt_reg;
   logic            wr_bank_reg, rd_bank_reg;
   logic            valid_reg, last_reg, overflow_reg;
   logic            rd_final, wr_free, rd_bank_eff;

   assign rd_en    = rd_ready_i && (bank_state[rd_bank_reg] == BANK_DRAIN);
   assign rd_final = rd_en && (rcnt_reg == LAST_IDX);

   // A bank on its final read is already free for the writer: the new frame
   // starts at address 0 while the read is at N-1, so the ports never collide.
   // Without this, streaming input would lose one sample per frame.
   assign wr_free = (bank_state[wr_bank_reg] == BANK_EMPTY) ||
                    (rd_final && (rd_bank_reg == wr_bank_reg));
   assign wr_en   = valid_i && wr_free;

   // Look ahead to the other bank on the final read so back-to-back frames
   // drain with no idle cycle between them.
   assign rd_bank_eff = rd_final ? ~rd_bank_reg : rd_bank_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_bank
         assign wr_done[gi]     = wr_en && (wcnt_reg == LAST_IDX) && (wr_bank_reg == 1'(gi));
         assign rd_done[gi]     = rd_final && (rd_bank_reg == 1'(gi));
         assign drain_start[gi] = (rd_bank_eff == 1'(gi)) && (bank_state[gi] == BANK_FULL);

         fft_bank_fsm u_bank (
            .clk         (clk),
            .rst_n       (rst_n),
            .wr_done     (wr_done[gi]),
            .drain_start (drain_start[gi]),
            .rd_done     (rd_done[gi]),
            .state       (bank_state[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wcnt_reg     <= '0;
         rcnt_reg     <= '0;
         wr_bank_reg  <= 1'b0;
         rd_bank_reg  <= 1'b0;
         valid_reg    <= 1'b0;
         last_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         if (wr_en) begin
            wcnt_reg <= wcnt_reg + 1'b1;
            if (wcnt_reg == LAST_IDX) wr_bank_reg <= ~wr_bank_reg;
         end
         if (rd_en) begin
            rcnt_reg <= rcnt_reg + 1'b1;
            if (rcnt_reg == LAST_IDX) rd_bank_reg <= ~rd_bank_reg;
         end
         valid_reg <= rd_en;
         last_reg  <= rd_final;
         if (valid_i && !wr_free) overflow_reg <= 1'b1;
      end
   end

   assign wr_bank  = wr_bank_reg;
   assign wr_addr  = LOGN'(bit_reverse(32'(wcnt_reg), LOGN));
   assign rd_bank  = rd_bank_reg;
   assign rd_addr  = rcnt_reg;
   assign valid_o  = valid_reg;
   assign last_o   = last_reg;
   assign overflow = overflow_reg;

endmodule

// File: tb/tb_fft_out_sched.sv
// Bench for fft_out_sched: frame-level reference model checked every cycle,
// directed scenarios with hand-computed expectations, then random traffic.
module tb_fft_out_sched;

   localparam int N    = 32;
   localparam int LOGN = 5;
   localparam int LOGSZ = 8192;

   logic            clk = 1'b0;
   logic            rst_n, valid_i, rd_ready_i;
   logic            wr_en, wr_bank, rd_en, rd_bank, valid_o, last_o, overflow;
   logic [LOGN-1:0] wr_addr, rd_addr;

   always #5 clk = ~clk;

   fft_out_sched #(.N(N), .LOGN(LOGN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (valid_i),
      .rd_ready_i (rd_ready_i),
      .wr_en      (wr_en),
      .wr_bank    (wr_bank),
      .wr_addr    (wr_addr),
      .rd_en      (rd_en),
      .rd_bank    (rd_bank),
      .rd_addr    (rd_addr),
      .valid_o    (valid_o),
      .last_o     (last_o),
      .overflow   (overflow)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: frames in flight, tracked by completion time.
   int m_wptr, m_rptr, m_wframe, m_rframe, m_last_read;
   int m_done_q[$];
   bit m_valid_o, m_last_o, m_overflow;

   // Logs of observed DUT activity for the directed checks.
   int wcount = 0, rcount = 0, vcount = 0, dcount = 0;
   int wlog [LOGSZ];
   int wbank_log [LOGSZ];
   int wcyc [LOGSZ];
   int rlog [LOGSZ];
   int rbank_log [LOGSZ];
   int vcyc [LOGSZ];
   int vlast [LOGSZ];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   function automatic int bitrev_model(input int v);
      int r = 0;
      for (int k = 0; k < LOGN; k++) r = r * 2 + ((v >> k) & 1);
      return r;
   endfunction

   task automatic model_reset();
      m_wptr = 0; m_rptr = 0; m_wframe = 0; m_rframe = 0;
      m_last_read = -1000;
      m_done_q.delete();
      m_valid_o = 0; m_last_o = 0; m_overflow = 0;
   endtask

   // Called once per cycle, mid-cycle: compare DUT against model, then advance.
   task automatic eval();
      int  start, live;
      bit  elig, e_rd_en, e_rd_final, e_wr_en;
      if (rst_n !== 1'b1) model_reset();
      elig = 0;
      if (m_done_q.size() > 0) begin
         start = m_done_q[0] + 2;
         if (m_last_read + 1 > start) start = m_last_read + 1;
         elig = (cyc >= start);
      end
      e_rd_en    = elig && (rd_ready_i === 1'b1);
      e_rd_final = e_rd_en && (m_rptr == N - 1);
      live       = m_done_q.size() - (e_rd_final ? 1 : 0);
      e_wr_en    = (valid_i === 1'b1) && ((m_wptr != 0) || (live < 2));

      chk("wr_en",    int'(wr_en),    int'(e_wr_en));
      chk("wr_addr",  int'(wr_addr),  bitrev_model(m_wptr));
      chk("wr_bank",  int'(wr_bank),  m_wframe % 2);
      chk("rd_en",    int'(rd_en),    int'(e_rd_en));
      chk("rd_addr",  int'(rd_addr),  m_rptr);
      chk("rd_bank",  int'(rd_bank),  m_rframe % 2);
      chk("valid_o",  int'(valid_o),  int'(m_valid_o));
      chk("last_o",   int'(last_o),   int'(m_last_o));
      chk("overflow", int'(overflow), int'(m_overflow));

      if (rst_n === 1'b1) begin
         if (wr_en === 1'b1 && wcount < LOGSZ) begin
            wlog[wcount] = int'(wr_addr); wbank_log[wcount] = int'(wr_bank); wcyc[wcount] = cyc;
            wcount++;
         end
         if (valid_i === 1'b1 && wr_en !== 1'b1) dcount++;
         if (rd_en === 1'b1 && rcount < LOGSZ) begin
            rlog[rcount] = int'(rd_addr); rbank_log[rcount] = int'(rd_bank);
            rcount++;
         end
         if (valid_o === 1'b1 && vcount < LOGSZ) begin
            vcyc[vcount] = cyc; vlast[vcount] = int'(last_o);
            vcount++;
         end

         if (e_wr_en) begin
            if (m_wptr == N - 1) begin
               m_done_q.push_back(cyc);
               m_wptr = 0;
               m_wframe++;
            end else m_wptr++;
         end
         if (valid_i === 1'b1 && !e_wr_en) m_overflow = 1;
         if (e_rd_en) begin
            if (e_rd_final) begin
               m_last_read = cyc;
               void'(m_done_q.pop_front());
               m_rptr = 0;
               m_rframe++;
            end else m_rptr++;
         end
         m_valid_o = e_rd_en;
         m_last_o  = e_rd_final;
      end
      cyc++;
   endtask

   task automatic tick(input bit v, input bit r);
      @(posedge clk); #1;
      valid_i = v; rd_ready_i = r;
      @(negedge clk);
      eval();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 0; valid_i = 0; rd_ready_i = 0;
      @(negedge clk);
      eval();
      chk("rst_wr_en",    int'(wr_en),    0);
      chk("rst_wr_addr",  int'(wr_addr),  0);
      chk("rst_wr_bank",  int'(wr_bank),  0);
      chk("rst_rd_en",    int'(rd_en),    0);
      chk("rst_rd_addr",  int'(rd_addr),  0);
      chk("rst_rd_bank",  int'(rd_bank),  0);
      chk("rst_valid_o",  int'(valid_o),  0);
      chk("rst_last_o",   int'(last_o),   0);
      chk("rst_overflow", int'(overflow), 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(negedge clk);
      eval();
   endtask

   // Directed checks shared by single-frame scenarios.
   task automatic check_frame(input string tag, input int w0, input int r0, input int v0);
      int exp_wa [5];
      int lsum;
      exp_wa = '{0, 16, 8, 24, 4};
      chk({tag, "_writes"}, wcount - w0, 32);
      for (int k = 0; k < 5; k++) chk({tag, "_wr_addr_seq"}, wlog[w0 + k], exp_wa[k]);
      chk({tag, "_wr_addr_last"}, wlog[w0 + 31], 31);
      chk({tag, "_reads"}, rcount - r0, 32);
      for (int k = 0; k < 32; k++) chk({tag, "_rd_addr_seq"}, rlog[r0 + k], k);
      chk({tag, "_valid_o_count"}, vcount - v0, 32);
      chk({tag, "_latency"}, vcyc[v0] - wcyc[w0 + 31], 3);
      lsum = 0;
      for (int k = 0; k < 32; k++) lsum += vlast[v0 + k];
      chk({tag, "_last_count"}, lsum, 1);
      chk({tag, "_last_pos"}, vlast[v0 + 31], 1);
   endtask

   initial begin
      int w0, r0, v0, d0;
      rst_n = 0; valid_i = 0; rd_ready_i = 0;
      model_reset();

      // Single frame, continuous input.
      do_reset();
      w0 = wcount; r0 = rcount; v0 = vcount;
      for (int i = 0; i < 32; i++) tick(1, 1);
      for (int i = 0; i < 40; i++) tick(0, 1);
      check_frame("single", w0, r0, v0);
      $display("single frame: writes=%0d reads=%0d valid_o=%0d", wcount - w0, rcount - r0, vcount - v0);

      // Three frames back to back.
      do_reset();
      w0 = wcount; v0 = vcount;
      for (int i = 0; i < 96; i++) tick(1, 1);
      for (int i = 0; i < 80; i++) tick(0, 1);
      chk("b2b_bank0", wbank_log[w0], 0);
      chk("b2b_bank1", wbank_log[w0 + 32], 1);
      chk("b2b_bank2", wbank_log[w0 + 64], 0);
      chk("b2b_valid_o_count", vcount - v0, 96);
      chk("b2b_overflow", int'(overflow), 0);
      $display("back-to-back: writes=%0d valid_o=%0d overflow=%0d", wcount - w0, vcount - v0, overflow);

      // Backpressure long enough to fill both banks.
      do_reset();
      w0 = wcount; v0 = vcount; d0 = dcount;
      for (int i = 0; i < 96; i++) begin
         tick(1, i >= 70);
         if (i == 64) chk("bp_overflow_at_drop", int'(overflow), 0);
         if (i == 65) chk("bp_overflow_after_drop", int'(overflow), 1);
      end
      for (int i = 0; i < 80; i++) tick(0, 1);
      chk("bp_accepted", wcount - w0, 64);
      chk("bp_dropped", dcount - d0, 32);
      chk("bp_valid_o_count", vcount - v0, 64);
      chk("bp_overflow_sticky", int'(overflow), 1);
      $display("backpressure: accepted=%0d dropped=%0d valid_o=%0d", wcount - w0, dcount - d0, vcount - v0);

      // Reader stalled on alternate cycles.
      do_reset();
      w0 = wcount; r0 = rcount; v0 = vcount;
      for (int i = 0; i < 32; i++) tick(1, i[0]);
      for (int i = 0; i < 80; i++) tick(0, i[0]);
      chk("stall_reads", rcount - r0, 32);
      chk("stall_valid_o_count", vcount - v0, 32);
      for (int k = 0; k < 32; k++) chk("stall_rd_addr_seq", rlog[r0 + k], k);
      $display("stall: reads=%0d valid_o=%0d", rcount - r0, vcount - v0);

      // Gapped input on alternate cycles.
      do_reset();
      w0 = wcount; r0 = rcount; v0 = vcount;
      for (int i = 0; i < 63; i++) tick(i % 2 == 0, 1);
      for (int i = 0; i < 40; i++) tick(0, 1);
      chk("gap_span", wcyc[w0 + 31] - wcyc[w0], 62);
      check_frame("gap", w0, r0, v0);
      $display("gapped: writes=%0d span=%0d valid_o=%0d", wcount - w0, wcyc[w0 + 31] - wcyc[w0], vcount - v0);

      // Reset after a partial frame, then a clean frame.
      do_reset();
      v0 = vcount;
      for (int i = 0; i < 20; i++) tick(1, 1);
      do_reset();
      chk("mid_rst_no_output", vcount - v0, 0);
      w0 = wcount; r0 = rcount; v0 = vcount;
      for (int i = 0; i < 32; i++) tick(1, 1);
      for (int i = 0; i < 40; i++) tick(0, 1);
      chk("mid_rst_rd_bank", rbank_log[r0], 0);
      check_frame("mid_rst", w0, r0, v0);
      $display("mid-frame reset: writes=%0d valid_o=%0d first rd_bank=%0d", wcount - w0, vcount - v0, rbank_log[r0]);

      // Random traffic with occasional resets.
      do_reset();
      w0 = wcount; v0 = vcount;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 799) == 0) do_reset();
         else tick($urandom_range(0, 99) < 70, $urandom_range(0, 99) < (i < 1500 ? 95 : 55));
      end
      for (int i = 0; i < 100; i++) tick(0, 1);
      $display("random: writes=%0d valid_o=%0d", wcount - w0, vcount - v0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
